pwm_fade_ctrl: RTL and testbench



---
 rtl/pwm_fade_ctrl.sv | 138 +++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// Per-channel duty fader: config writes set targets, each fade tick sweeps all channels stepping duty toward target.
// Optional macro PWM_FADE_INSTANT_EN adds cfg_instant, which loads target and current duty together.
module pwm_fade_ctrl #(
  parameter int CH        = 4,
  parameter int CH_BITS   = 2,
  parameter int DATA_W    = 8,
  parameter int TICK_DIV  = 1000,
  parameter int TICK_BITS = 10,
  parameter int STEP      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_BITS-1:0]   cfg_ch,
  input  logic [DATA_W-1:0]    cfg_target,
`ifdef PWM_FADE_INSTANT_EN
  input  logic                 cfg_instant,
`endif
  output logic [CH*DATA_W-1:0] duty_out,
  output logic [CH-1:0]        en_out,
  output logic [CH-1:0]        done,
  output logic                 busy
);

  typedef enum logic {S_IDLE, S_SWEEP} state_e;

  localparam logic [31:0] CH_U = 32'(CH);

  state_e               state_q;
  logic [TICK_BITS-1:0] tick_cnt_q;
  logic [CH_BITS-1:0]   idx_q;
  logic [DATA_W-1:0]    cur_q [CH];
  logic [DATA_W-1:0]    tgt_q [CH];
  logic [CH-1:0]        en_q;
  logic [CH-1:0]        done_q;
  logic                 ready_q;
  logic                 busy_q;

  logic                 tick;
  logic                 wr_hit;
  logic [DATA_W-1:0]    vis_cur;
  logic [DATA_W-1:0]    vis_tgt;
  logic [DATA_W-1:0]    vis_next;
  logic [DATA_W-1:0]    step_w;

  assign tick   = (tick_cnt_q == TICK_BITS'(TICK_DIV - 1));
  // Out-of-range channel writes still complete the handshake but touch nothing.
  assign wr_hit = cfg_valid && ready_q && (32'(cfg_ch) < CH_U);
  assign step_w = DATA_W'(STEP);

  always_comb begin
    vis_cur  = cur_q[idx_q];
    vis_tgt  = tgt_q[idx_q];
    vis_next = vis_cur;
    if (vis_cur < vis_tgt) begin
      vis_next = ((vis_tgt - vis_cur) > step_w) ? vis_cur + step_w : vis_tgt;
    end else if (vis_cur > vis_tgt) begin
      vis_next = ((vis_cur - vis_tgt) > step_w) ? vis_cur - step_w : vis_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      en_q    <= '0;
      done_q  <= '0;
      for (int i = 0; i < CH; i++) begin
        cur_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (wr_hit) begin
            tgt_q[cfg_ch] <= cfg_target;
`ifdef PWM_FADE_INSTANT_EN
            if (cfg_instant) begin
              cur_q[cfg_ch] <= cfg_target;
              en_q[cfg_ch]  <= (cfg_target != '0);
            end
`endif
          end
          if (tick) begin
            state_q <= S_SWEEP;
            idx_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_SWEEP: begin
          if (vis_cur != vis_tgt) begin
            cur_q[idx_q]  <= vis_next;
            en_q[idx_q]   <= (vis_next != '0);
            done_q[idx_q] <= (vis_next == vis_tgt);
          end
          if (idx_q == CH_BITS'(CH - 1)) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_duty
    assign duty_out[g*DATA_W +: DATA_W] = cur_q[g];
  end

  assign en_out    = en_q;
  assign done      = done_q;
  assign cfg_ready = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: a cycle-numbered reference model queues expected status and duty events,
// a monitor pops and compares them whenever the DUT presents a duty change or done pulse.
`timescale 1ns/1ps
module tb_pwm_fade_ctrl;
  localparam int CH = 4, CB = 3, DW = 8, D = 10, TB = 4, STEP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [CB-1:0] cfg_ch = '0;
  logic [DW-1:0] cfg_target = '0;
  logic [CH*DW-1:0] duty_out;
  logic [CH-1:0] en_out, done;
  logic busy;

  pwm_fade_ctrl #(.CH(CH), .CH_BITS(CB), .DATA_W(DW), .TICK_DIV(D), .TICK_BITS(TB), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_target(cfg_target),
`ifdef PWM_FADE_INSTANT_EN
    .cfg_instant(1'b0),
`endif
    .duty_out(duty_out), .en_out(en_out), .done(done), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {int cyc; bit rdy; bit bsy;} st_t;
  typedef struct {int cyc; int ch; int duty; bit dn;} ev_t;

  st_t st_q[$];
  ev_t ev_q[$];
  int  m_cur[CH];
  int  m_tgt[CH];
  int  prev[CH];
  int  dcyc = 0;
  int  mcyc = 0;
  bit  mon_on = 1'b0;
  int  n_chk = 0;
  int  n_err = 0;

  task automatic chk(input bit ok, input string name, input string act, input string exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %s, expected %s (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcyc <= 0;
    else        mcyc <= mcyc + 1;
  end

  // Model: cycle n ticks when n%D==D-1; the following CH cycles visit channels 0..CH-1.
  task automatic step(input bit v, input int ch, input int tg, output bit acc);
    int  ph, c, t, nv;
    bit  sweep;
    cfg_valid  = v;
    cfg_ch     = CB'(ch);
    cfg_target = DW'(tg);
    ph    = dcyc % D;
    sweep = (dcyc >= D) && (ph < CH);
    st_q.push_back('{dcyc, !sweep, sweep});
    if (sweep) begin
      c = m_cur[ph];
      t = m_tgt[ph];
      if (c != t) begin
        nv = (c < t) ? c + ((t - c) < STEP ? (t - c) : STEP)
                     : c - ((c - t) < STEP ? (c - t) : STEP);
        m_cur[ph] = nv;
        ev_q.push_back('{dcyc + 1, ph, nv, nv == t});
      end
    end
    acc = v && !sweep;
    if (acc && ch < CH) m_tgt[ch] = tg;
    @(negedge clk);
    dcyc++;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, a);
  endtask

  task automatic do_write(input int ch, input int tg);
    bit a = 1'b0;
    for (int k = 0; k < 50 && !a; k++) step(1'b1, ch, tg, a);
    cfg_valid = 1'b0;
  endtask

  task automatic drain_and_compare(input string tag);
    bit conv = 1'b0;
    for (int k = 0; k < 3000 && !conv; k++) begin
      conv = 1'b1;
      for (int i = 0; i < CH; i++) if (m_cur[i] != m_tgt[i]) conv = 1'b0;
      if (!conv) idle(1);
    end
    chk(conv, {tag, "_converge"}, "not converged", "converged");
    idle(2);
    for (int i = 0; i < CH; i++)
      chk(duty_out[i*DW +: DW] == DW'(m_cur[i]), {tag, "_duty"},
          $sformatf("ch%0d=%0d", i, duty_out[i*DW +: DW]), $sformatf("ch%0d=%0d", i, m_cur[i]));
    chk(ev_q.size() == 0, {tag, "_pending"}, $sformatf("%0d events unseen", ev_q.size()), "0");
  endtask

  // Monitor samples mid-cycle, after the driver has queued this cycle's expectations.
  always begin
    st_t s;
    ev_t e;
    int  nchg, chg;
    @(negedge clk);
    #2;
    if (mon_on && rst_n) begin
      if (st_q.size() == 0) begin
        chk(1'b0, "status_underflow", "empty", "record");
      end else begin
        s = st_q.pop_front();
        chk(s.cyc == mcyc && cfg_ready == s.rdy && busy == s.bsy, "status",
            $sformatf("cyc=%0d ready=%b busy=%b", mcyc, cfg_ready, busy),
            $sformatf("cyc=%0d ready=%b busy=%b", s.cyc, s.rdy, s.bsy));
      end
      nchg = 0;
      chg  = -1;
      for (int i = 0; i < CH; i++)
        if (int'(duty_out[i*DW +: DW]) != prev[i]) begin nchg++; chg = i; end
      if (nchg > 0 || done != '0) begin
        if (ev_q.size() == 0) begin
          chk(1'b0, "unexpected_update", $sformatf("cyc=%0d ch=%0d done=%b", mcyc, chg, done), "no update");
        end else begin
          e = ev_q.pop_front();
          chk(e.cyc == mcyc && nchg == 1 && chg == e.ch &&
              duty_out[e.ch*DW +: DW] == DW'(e.duty) && en_out[e.ch] == (e.duty != 0) &&
              done == (e.dn ? CH'(1) << e.ch : CH'(0)), "duty_event",
              $sformatf("cyc=%0d nchg=%0d ch=%0d duty=%0d en=%b done=%b", mcyc, nchg, chg,
                        duty_out[e.ch*DW +: DW], en_out[e.ch], done),
              $sformatf("cyc=%0d nchg=1 ch=%0d duty=%0d en=%b done=%b", e.cyc, e.ch, e.duty,
                        e.duty != 0, e.dn ? CH'(1) << e.ch : CH'(0)));
        end
      end
      for (int i = 0; i < CH; i++) prev[i] = int'(duty_out[i*DW +: DW]);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin m_cur[i] = 0; m_tgt[i] = 0; prev[i] = 0; end
    st_q.delete();
    ev_q.delete();
  endtask

  initial begin
    bit a;
    int guard;
    model_reset();
    repeat (3) @(negedge clk);
    chk(duty_out == '0 && en_out == '0 && done == '0 && busy == 1'b0 && cfg_ready == 1'b1, "reset_state",
        $sformatf("duty=%h en=%b done=%b busy=%b ready=%b", duty_out, en_out, done, busy, cfg_ready),
        "duty=0 en=0 done=0 busy=0 ready=1");
    rst_n = 1'b1;
    dcyc = 0;
    mon_on = 1'b1;

    idle(12);
    do_write(1, 3);
    idle(40);
    do_write(0, 10);
    idle(60);
    do_write(0, 0);
    idle(60);

    guard = 0;
    while (!(dcyc >= D && dcyc % D == 1) && guard < 50) begin idle(1); guard++; end
    do_write(2, 5);
    idle(50);

    guard = 0;
    while (dcyc % D != D - 1 && guard < 50) begin idle(1); guard++; end
    step(1'b1, 3, 77, a);
    do_write(0, 200);
    guard = 0;
    while (m_cur[0] < 20 && guard < 500) begin idle(1); guard++; end
    do_write(0, 50);
    drain_and_compare("directed");

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0)
        step(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), a);
      else
        step(1'b0, 0, 0, a);
    end
    drain_and_compare("random");

    for (int i = 0; i < CH; i++) do_write(i, 200);
    guard = 0;
    while (!(dcyc >= D && dcyc % D == 2 && m_cur[0] != 0) && guard < 500) begin idle(1); guard++; end
    mon_on = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk(duty_out == '0 && en_out == '0 && done == '0 && busy == 1'b0 && cfg_ready == 1'b1, "async_reset",
        $sformatf("duty=%h en=%b done=%b busy=%b ready=%b", duty_out, en_out, done, busy, cfg_ready),
        "duty=0 en=0 done=0 busy=0 ready=1");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    dcyc = 0;
    mon_on = 1'b1;
    idle(3);
    do_write(3, 9);
    drain_and_compare("post_reset");

    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
